// File: rtl/alu_exec_sequencer.sv
// Multi-cycle control sequencer for the 32-bit ALU datapath.
// One instruction per start/done handshake: load Y, run the ALU (with
// programmable settle cycles for multiply/divide), capture Z, then write
// Z back to a GPR (single-result ops) or to LO/HI (mul/div).
// All outputs are registered; they are decoded from the next-state values
// so each strobe appears in the same cycle as the state it belongs to.
module alu_exec_sequencer #(
    parameter logic [3:0] MUL_WAIT = 4'd1,
    parameter logic [3:0] DIV_WAIT = 4'd4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] op_in,
    output logic [4:0] alu_opcode,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Zhighout,
    output logic       Rin,
    output logic       LOin,
    output logic       HIin,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       halted
);

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_EXEC,
        ST_WB_LO,
        ST_WB_LO2,
        ST_WB_HI,
        ST_DONE,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU1,
        CLS_ALU2,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    // Opcode class decode shared by the next-state and output logic.
    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
            5'b01101, 5'b10000, 5'b10001: cls = CLS_ALU1;
            5'b01110, 5'b01111:           cls = CLS_ALU2;
            5'b11001:                     cls = CLS_NOP;
            5'b11010:                     cls = CLS_HALT;
            default:                      cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] op_r;
    logic [4:0] op_next_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;

    logic [4:0] alu_opcode_s;
    logic       yin_s, zin_s, zlowout_s, zhighout_s, rin_s, loin_s, hiin_s;
    logic       busy_s, done_s, illegal_s, halted_s;

    logic [4:0] alu_opcode_r;
    logic       yin_r, zin_r, zlowout_r, zhighout_r, rin_r, loin_r, hiin_r;
    logic       busy_r, done_r, illegal_r, halted_r;

    // Next-state, opcode latch and settle-counter logic.
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_next_s = op_in;
                    case (op_class(op_in))
                        CLS_ALU1, CLS_ALU2: state_next_s = ST_LOAD_A;
                        CLS_NOP:            state_next_s = ST_DONE;
                        CLS_HALT:           state_next_s = ST_HALT;
                        default:            state_next_s = ST_DONE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                if (op_r == OP_MUL) begin
                    cnt_next_s = MUL_WAIT;
                end else if (op_r == OP_DIV) begin
                    cnt_next_s = DIV_WAIT;
                end else begin
                    cnt_next_s = 4'd0;
                end
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_r != 4'd0) begin
                    cnt_next_s = cnt_r - 4'd1;
                end else if (op_class(op_r) == CLS_ALU2) begin
                    state_next_s = ST_WB_LO2;
                end else begin
                    state_next_s = ST_WB_LO;
                end
            end
            ST_WB_LO:  state_next_s = ST_DONE;
            ST_WB_LO2: state_next_s = ST_WB_HI;
            ST_WB_HI:  state_next_s = ST_DONE;
            ST_DONE:   state_next_s = ST_IDLE;
            ST_HALT:   state_next_s = ST_HALT;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the state being entered, so registered strobes line up with it.
    always_comb begin
        alu_opcode_s = 5'd0;
        yin_s        = 1'b0;
        zin_s        = 1'b0;
        zlowout_s    = 1'b0;
        zhighout_s   = 1'b0;
        rin_s        = 1'b0;
        loin_s       = 1'b0;
        hiin_s       = 1'b0;
        done_s       = 1'b0;
        illegal_s    = 1'b0;
        halted_s     = 1'b0;
        busy_s       = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_LOAD_A: begin
                alu_opcode_s = op_next_s;
                yin_s        = 1'b1;
            end
            ST_EXEC: begin
                alu_opcode_s = op_next_s;
                zin_s        = (cnt_next_s == 4'd0);
            end
            ST_WB_LO: begin
                alu_opcode_s = op_next_s;
                zlowout_s    = 1'b1;
                rin_s        = 1'b1;
            end
            ST_WB_LO2: begin
                alu_opcode_s = op_next_s;
                zlowout_s    = 1'b1;
                loin_s       = 1'b1;
            end
            ST_WB_HI: begin
                alu_opcode_s = op_next_s;
                zhighout_s   = 1'b1;
                hiin_s       = 1'b1;
            end
            ST_DONE: begin
                done_s    = 1'b1;
                illegal_s = (op_class(op_next_s) == CLS_ILL);
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                alu_opcode_s = 5'd0;
            end
        endcase
    end

    // State, opcode latch and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= 5'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            op_r    <= op_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered output stage; reset forces every output low.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_opcode_r <= 5'd0;
            yin_r        <= 1'b0;
            zin_r        <= 1'b0;
            zlowout_r    <= 1'b0;
            zhighout_r   <= 1'b0;
            rin_r        <= 1'b0;
            loin_r       <= 1'b0;
            hiin_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            illegal_r    <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            alu_opcode_r <= alu_opcode_s;
            yin_r        <= yin_s;
            zin_r        <= zin_s;
            zlowout_r    <= zlowout_s;
            zhighout_r   <= zhighout_s;
            rin_r        <= rin_s;
            loin_r       <= loin_s;
            hiin_r       <= hiin_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            illegal_r    <= illegal_s;
            halted_r     <= halted_s;
        end
    end

    assign alu_opcode = alu_opcode_r;
    assign Yin        = yin_r;
    assign Zin        = zin_r;
    assign Zlowout    = zlowout_r;
    assign Zhighout   = zhighout_r;
    assign Rin        = rin_r;
    assign LOin       = loin_r;
    assign HIin       = hiin_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign illegal    = illegal_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer. Expected per-cycle output
// vectors come from a timing model: class of the opcode plus the latency
// formulas (Yin at +1, Zin at +2+wait, writebacks after, done at latency).
module tb_alu_exec_sequencer;

    localparam logic [3:0] MUL_W = 4'd1;
    localparam logic [3:0] DIV_W = 4'd4;

    logic       clock;
    logic       reset;
    logic       start;
    logic [4:0] op_in;
    logic [4:0] alu_opcode;
    logic       Yin, Zin, Zlowout, Zhighout, Rin, LOin, HIin;
    logic       busy, done, illegal, halted;

    int n_cmp;
    int n_bad;

    alu_exec_sequencer #(
        .MUL_WAIT(MUL_W),
        .DIV_WAIT(DIV_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .op_in(op_in),
        .alu_opcode(alu_opcode),
        .Yin(Yin),
        .Zin(Zin),
        .Zlowout(Zlowout),
        .Zhighout(Zhighout),
        .Rin(Rin),
        .LOin(LOin),
        .HIin(HIin),
        .busy(busy),
        .done(done),
        .illegal(illegal),
        .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed output vector: {alu_opcode, Yin, Zin, Zlo, Zhi, Rin, LOin, HIin, busy, done, illegal, halted}
    function automatic logic [15:0] obs();
        return {alu_opcode, Yin, Zin, Zlowout, Zhighout, Rin, LOin, HIin,
                busy, done, illegal, halted};
    endfunction

    // 0 = single writeback, 1 = mul/div, 2 = nop, 3 = halt, 4 = illegal
    function automatic int model_class(input logic [4:0] op);
        int alu1 [13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 17};
        for (int i = 0; i < 13; i++) begin
            if (int'(op) == alu1[i]) return 0;
        end
        if (op == 5'd14 || op == 5'd15) return 1;
        if (op == 5'd25) return 2;
        if (op == 5'd26) return 3;
        return 4;
    endfunction

    function automatic int model_wait(input logic [4:0] op);
        if (op == 5'd14) return int'(MUL_W);
        if (op == 5'd15) return int'(DIV_W);
        return 0;
    endfunction

    function automatic int model_latency(input logic [4:0] op);
        int c;
        c = model_class(op);
        if (c == 0) return 4;
        if (c == 1) return 5 + model_wait(op);
        return 1;
    endfunction

    // Expected outputs k cycles after the start-sampling edge.
    function automatic logic [15:0] model_vec(input logic [4:0] op, input int k);
        int c, w, lat;
        logic alu;
        logic [4:0] ao;
        c   = model_class(op);
        w   = model_wait(op);
        lat = model_latency(op);
        alu = (c == 0 || c == 1);
        ao  = (alu && k >= 1 && k <= lat - 1) ? op : 5'd0;
        return {ao,
                alu && k == 1,
                alu && k == 2 + w,
                alu && k == 3 + w,
                c == 1 && k == 4 + w,
                c == 0 && k == 3,
                c == 1 && k == 3 + w,
                c == 1 && k == 4 + w,
                k >= 1 && k <= lat,
                k == lat,
                c == 4 && k == lat,
                1'b0};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one non-halt instruction and check every cycle through the idle cycle after done.
    task automatic run_op(input logic [4:0] op, input bit noise, input string name);
        int lat;
        logic [15:0] e;
        lat = model_latency(op);
        start = 1'b1;
        op_in = op;
        step();
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            e = model_vec(op, k);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL %s op=%b cyc=%0d got=%h want=%h", name, op, k, obs(), e);
            end
            if (noise && $urandom_range(0, 1) == 0) begin
                start = 1'b1;
                op_in = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (obs() !== 16'd0) begin
            n_bad++;
            $display("FAIL %s_idle op=%b got=%h want=0000", name, op, obs());
        end
    endtask

    task automatic idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            step();
            n_cmp++;
            if (obs() !== 16'd0) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got=%h want=0000", name, i, obs());
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_in = 5'd0;
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if (obs() !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=0000", obs());
        end
        idle_check(2, "reset_idle");
    endtask

    task automatic test_alu1();
        run_op(5'b00011, 1'b0, "add");
        run_op(5'b10001, 1'b0, "not");
        run_op(5'b01101, 1'b0, "ori");
    endtask

    task automatic test_mul_div();
        run_op(5'b01110, 1'b0, "mul");
        run_op(5'b01111, 1'b1, "div_ignored_start");
    endtask

    task automatic test_back_to_back();
        run_op(5'b10010, 1'b0, "illegal");
        run_op(5'b11001, 1'b0, "nop");
        run_op(5'b00000, 1'b0, "illegal0");
        run_op(5'b01001, 1'b0, "and");
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom);
            if (op == 5'b11010) op = 5'b11001;
            run_op(op, 1'b1, "random");
            if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3), "random_gap");
        end
    endtask

    task automatic test_reset_mid_div();
        logic [15:0] e;
        start = 1'b1;
        op_in = 5'b01111;
        step();
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            e = model_vec(5'b01111, k);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL div_pre_reset cyc=%0d got=%h want=%h", k, obs(), e);
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (obs() !== 16'd0) begin
            n_bad++;
            $display("FAIL div_abort got=%h want=0000", obs());
        end
        idle_check(8, "div_abort_quiet");
        run_op(5'b00011, 1'b0, "add_after_abort");
    endtask

    task automatic test_halt();
        logic [15:0] e;
        e = 16'd0;
        e[2] = 1'b0;
        e = {5'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        start = 1'b1;
        op_in = 5'b11010;
        step();
        for (int k = 1; k <= 20; k++) begin
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL halt_hold cyc=%0d got=%h want=%h", k, obs(), e);
            end
            start = 1'b1;
            op_in = 5'b00011;
            step();
        end
        start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (obs() !== 16'd0) begin
            n_bad++;
            $display("FAIL halt_reset got=%h want=0000", obs());
        end
        run_op(5'b00100, 1'b0, "sub_after_halt");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        op_in = 5'd0;
        test_reset();
        test_alu1();
        test_mul_div();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle control sequencer for the 32-bit ALU datapath.
- Accepts one ALU instruction per start/done handshake and latches its 5-bit opcode.
- Sequences the datapath strobes: Y load, ALU opcode select, Z capture, then Z low/high writeback to the register file or HI/LO.
- Inserts programmable wait cycles so the long combinational multiply and divide paths settle before Z captures.

Parameters:
- MUL_WAIT, 1: extra EXEC cycles before Zin for multiplication (0..15).
- DIV_WAIT, 4: extra EXEC cycles before Zin for division (0..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  request pulse; sampled only in IDLE.
- op_in  in  5  opcode presented with start.
- alu_opcode  out  5  opcode driven to the ALU select input.
- Yin  out  1  load Y register (operand A) from bus.
- Zin  out  1  capture the 64-bit ALU result into Z.
- Zlowout  out  1  drive Z[31:0] onto bus.
- Zhighout  out  1  drive Z[63:32] onto bus.
- Rin  out  1  write bus into destination GPR.
- LOin  out  1  write bus into LO.
- HIin  out  1  write bus into HI.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  high with done when the opcode is not ALU-class.
- halted  out  1  sticky after halt; cleared only by reset.

Behaviour:
- Reset (synchronous): state=IDLE, wait counter=0, latched opcode=0. Every output is 0, including alu_opcode, halted, busy, done and illegal. Reset mid-operation aborts the instruction in the following cycle with no further strobes.
- Opcode classes:
  - ALU1 (single writeback): 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or, 01011 addi, 01100 andi, 01101 ori, 10000 neg, 10001 not.
  - ALU2 (two writebacks): 01110 mul, 01111 div.
  - NOP: 11001. HALT: 11010.
  - All others are illegal.
- IDLE: start=1 latches op_in and moves to the next state by class:
  - ALU1 or ALU2 → LOAD_A.
  - NOP → DONE.
  - HALT → HALT.
  - Illegal → DONE with illegal flag set.
  - start=0 stays in IDLE. start while busy is ignored, with no queueing.
- LOAD_A (1 cycle): Yin=1. Counter loads MUL_WAIT for mul, DIV_WAIT for div, 0 otherwise. Next state is EXEC.
- EXEC: counter decrements each cycle while non-zero. Zin=1 on the cycle the counter equals 0, then:
  - ALU1 → WB_LO.
  - ALU2 → WB_LO2.
- WB_LO (ALU1, 1 cycle): Zlowout=1 and Rin=1. Next state is DONE.
- WB_LO2 (1 cycle): Zlowout=1 and LOin=1. Next state is WB_HI.
- WB_HI (1 cycle): Zhighout=1 and HIin=1. Next state is DONE.
- DONE (1 cycle): done=1. illegal=1 only if the latched opcode was illegal. Next state is IDLE, and start is first accepted on the cycle after DONE.
- HALT: halted=1 and busy=1 indefinitely. done is never pulsed; start is ignored. Only reset exits.
- alu_opcode equals the latched opcode from LOAD_A through WB_HI, and is 0 in IDLE, DONE and HALT.
- Strobes are mutually exclusive except the listed pairs: Zlowout+Rin, Zlowout+LOin, Zhighout+HIin. No strobe is active in IDLE, DONE or HALT.
- Latency, counted in cycles from the start-sampling edge to done high:
  - ALU1: 4.
  - mul/div: 5+WAIT, so mul=6 and div=9 at the defaults.
  - NOP and illegal: 1.
- busy rises the cycle after start is sampled. busy falls the cycle after DONE, when the state returns to IDLE.

Test Plan:
- Reset, then start with op_in=00011 (add) at cycle 0:
  - cycle 1: Yin=1.
  - cycle 2: Zin=1 with alu_opcode=00011.
  - cycle 3: Zlowout=1 and Rin=1.
  - cycle 4: done=1. cycle 5: busy=0.
- start with op_in=01110 (mul), MUL_WAIT=1:
  - EXEC lasts 2 cycles, with Zin only on the second.
  - LOin with Zlowout on cycle 4, HIin with Zhighout on cycle 5.
  - done on cycle 6. Rin is never asserted.
- start with op_in=01111 (div), DIV_WAIT=4:
  - Zin on cycle 6, LOin on cycle 7, HIin on cycle 8, done on cycle 9.
  - start pulses at cycles 3 and 9 are ignored, with no second done.
- start with op_in=10010 (branch, illegal):
  - done=1 and illegal=1 on cycle 1, with no strobes.
  - Then start with op_in=11001 (nop): done=1, illegal=0 on the next cycle.
- start with op_in=11010 (halt):
  - halted=1 and busy=1 from cycle 1.
  - start with op_in=00011 is ignored for 20 cycles.
  - Asserting reset clears halted and busy on the next edge.
- Assert reset during EXEC of div (cycle 3):
  - From the next edge: state IDLE, all outputs 0, no Zin, LOin or done.
  - A subsequent add completes with the 4-cycle latency.
